// File: rtl/ascii_mon_pkg.sv
// Shared definitions for the ASCII stream monitor.
// Holds the ASCII code points the monitor reacts to and the word/separator
// state type used by the message-tracking FSM.
package ascii_mon_pkg;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_DOT = 8'h2E;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_WORD = 2'd1,
        IN_SEP  = 2'd2
    } state_t;

endpackage

// File: rtl/ascii_byte_classifier.sv
// Combinational byte classifier for the ASCII stream monitor.
// Ports:
//   din     - stream byte
//   is_sep  - byte is a separator (space or any byte below 0x20)
//   is_lf   - byte is a line feed
//   is_dot  - byte is a full stop
//   is_ctrl - control byte other than LF/CR
//   is_ext  - byte has the top bit set (>= 0x80)
module ascii_byte_classifier (
    input  logic [7:0] din,
    output logic       is_sep,
    output logic       is_lf,
    output logic       is_dot,
    output logic       is_ctrl,
    output logic       is_ext
);
    import ascii_mon_pkg::*;

    // Decode byte classes; 0x7F and everything from 0x21 up count as word bytes
    always_comb begin
        is_lf   = (din == ASCII_LF);
        is_dot  = (din == ASCII_DOT);
        is_sep  = (din <= ASCII_SP);
        is_ctrl = (din < ASCII_SP) && (din != ASCII_LF) && (din != ASCII_CR);
        is_ext  = din[7];
    end

endmodule

// File: rtl/ascii_stream_monitor.sv
// Characterises a byte-per-clock ASCII stream message by message.
// A message ends on ".\n" or after TIMEOUT idle cycles while one is in progress;
// at that point the live counts are latched into the msg_* summary outputs and
// msg_done pulses on the following cycle.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   clear           - synchronous abort of the message in progress (summary kept)
//   din, din_valid  - stream byte and its qualifier
//   busy            - a message is in progress
//   msg_done        - one-cycle pulse, summary just updated
//   msg_chars/words/lines/sum - summary counts of the last message
//   msg_timeout, ext_flag, ctrl_err, ovf - summary flags of the last message
module ascii_stream_monitor #(
    parameter int CNT_W   = 12,
    parameter int WRD_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             busy,
    output logic             msg_done,
    output logic [CNT_W-1:0] msg_chars,
    output logic [WRD_W-1:0] msg_words,
    output logic [WRD_W-1:0] msg_lines,
    output logic [7:0]       msg_sum,
    output logic             msg_timeout,
    output logic             ext_flag,
    output logic             ctrl_err,
    output logic             ovf
);
    import ascii_mon_pkg::*;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    // The timeout fires on the edge where the idle count would reach TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic is_sep_s, is_lf_s, is_dot_s, is_ctrl_s, is_ext_s;

    ascii_byte_classifier u_classifier (
        .din     (din),
        .is_sep  (is_sep_s),
        .is_lf   (is_lf_s),
        .is_dot  (is_dot_s),
        .is_ctrl (is_ctrl_s),
        .is_ext  (is_ext_s)
    );

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] chars_r, chars_upd_s;
    logic [WRD_W-1:0] words_r, words_upd_s;
    logic [WRD_W-1:0] lines_r, lines_upd_s;
    logic [7:0]       sum_r, sum_upd_s;
    logic             ctrl_r, ctrl_upd_s;
    logic             ext_r, ext_upd_s;
    logic             ovf_r, ovf_upd_s;
    logic             dot_seen_r;
    logic [TO_W-1:0]  idle_r;
    logic             acc_s, eom_term_s, eom_to_s;

    assign acc_s      = din_valid && !clear;
    assign eom_term_s = acc_s && is_lf_s && dot_seen_r;
    assign eom_to_s   = TO_EN && !clear && !din_valid && (state_r != IDLE) && (idle_r == TO_LAST);
    assign busy       = (state_r != IDLE);

    // Live counter values as they would be after accepting the current byte
    always_comb begin
        chars_upd_s = chars_r;
        words_upd_s = words_r;
        lines_upd_s = lines_r;
        sum_upd_s   = sum_r + din;
        ctrl_upd_s  = ctrl_r | is_ctrl_s;
        ext_upd_s   = ext_r | is_ext_s;
        ovf_upd_s   = ovf_r;
        if (&chars_r) begin
            ovf_upd_s = 1'b1;
        end else begin
            chars_upd_s = chars_r + CNT_W'(1);
        end
        // A word starts on a word byte that does not continue the previous one.
        if ((state_r != IN_WORD) && !is_sep_s) begin
            if (&words_r) begin
                ovf_upd_s = 1'b1;
            end else begin
                words_upd_s = words_r + WRD_W'(1);
            end
        end else begin
            words_upd_s = words_r;
        end
        if (is_lf_s) begin
            if (&lines_r) begin
                ovf_upd_s = 1'b1;
            end else begin
                lines_upd_s = lines_r + WRD_W'(1);
            end
        end else begin
            lines_upd_s = lines_r;
        end
    end

    // Next-state logic: any accepted byte selects word/separator state by its class
    always_comb begin
        state_nx_s = state_r;
        if (clear) begin
            state_nx_s = IDLE;
        end else if (acc_s) begin
            if (eom_term_s) begin
                state_nx_s = IDLE;
            end else if (is_sep_s) begin
                state_nx_s = IN_SEP;
            end else begin
                state_nx_s = IN_WORD;
            end
        end else if (eom_to_s) begin
            state_nx_s = IDLE;
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Live counters, idle timer, and summary registers latched at end of message
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chars_r     <= '0;
            words_r     <= '0;
            lines_r     <= '0;
            sum_r       <= 8'h00;
            ctrl_r      <= 1'b0;
            ext_r       <= 1'b0;
            ovf_r       <= 1'b0;
            dot_seen_r  <= 1'b0;
            idle_r      <= '0;
            msg_done    <= 1'b0;
            msg_chars   <= '0;
            msg_words   <= '0;
            msg_lines   <= '0;
            msg_sum     <= 8'h00;
            msg_timeout <= 1'b0;
            ext_flag    <= 1'b0;
            ctrl_err    <= 1'b0;
            ovf         <= 1'b0;
        end else if (clear) begin
            chars_r    <= '0;
            words_r    <= '0;
            lines_r    <= '0;
            sum_r      <= 8'h00;
            ctrl_r     <= 1'b0;
            ext_r      <= 1'b0;
            ovf_r      <= 1'b0;
            dot_seen_r <= 1'b0;
            idle_r     <= '0;
            msg_done   <= 1'b0;
        end else begin
            msg_done <= eom_term_s || eom_to_s;
            if (acc_s || (state_r == IDLE) || eom_to_s || !TO_EN) begin
                idle_r <= '0;
            end else begin
                idle_r <= idle_r + TO_W'(1);
            end
            if (eom_term_s) begin
                // Summary includes the terminating LF itself.
                msg_chars   <= chars_upd_s;
                msg_words   <= words_upd_s;
                msg_lines   <= lines_upd_s;
                msg_sum     <= sum_upd_s;
                msg_timeout <= 1'b0;
                ext_flag    <= ext_upd_s;
                ctrl_err    <= ctrl_upd_s;
                ovf         <= ovf_upd_s;
                chars_r     <= '0;
                words_r     <= '0;
                lines_r     <= '0;
                sum_r       <= 8'h00;
                ctrl_r      <= 1'b0;
                ext_r       <= 1'b0;
                ovf_r       <= 1'b0;
                dot_seen_r  <= 1'b0;
            end else if (acc_s) begin
                chars_r    <= chars_upd_s;
                words_r    <= words_upd_s;
                lines_r    <= lines_upd_s;
                sum_r      <= sum_upd_s;
                ctrl_r     <= ctrl_upd_s;
                ext_r      <= ext_upd_s;
                ovf_r      <= ovf_upd_s;
                dot_seen_r <= is_dot_s;
            end else if (eom_to_s) begin
                msg_chars   <= chars_r;
                msg_words   <= words_r;
                msg_lines   <= lines_r;
                msg_sum     <= sum_r;
                msg_timeout <= 1'b1;
                ext_flag    <= ext_r;
                ctrl_err    <= ctrl_r;
                ovf         <= ovf_r;
                chars_r     <= '0;
                words_r     <= '0;
                lines_r     <= '0;
                sum_r       <= 8'h00;
                ctrl_r      <= 1'b0;
                ext_r       <= 1'b0;
                ovf_r       <= 1'b0;
                dot_seen_r  <= 1'b0;
            end else begin
                chars_r    <= chars_r;
                dot_seen_r <= dot_seen_r;
            end
        end
    end

endmodule

// File: tb/tb_ascii_stream_monitor.sv
module tb_ascii_stream_monitor;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset, clear, din_valid;
    logic [7:0] din;

    logic        busy, msg_done, msg_timeout, ext_flag, ctrl_err, ovf;
    logic [11:0] msg_chars;
    logic [7:0]  msg_words, msg_lines, msg_sum;

    logic        s_busy, s_done, s_timeout, s_ext, s_ctrl, s_ovf;
    logic [2:0]  s_chars;
    logic [7:0]  s_words, s_lines, s_sum;

    ascii_stream_monitor #(.CNT_W(12), .WRD_W(8), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
        .busy(busy), .msg_done(msg_done), .msg_chars(msg_chars), .msg_words(msg_words),
        .msg_lines(msg_lines), .msg_sum(msg_sum), .msg_timeout(msg_timeout),
        .ext_flag(ext_flag), .ctrl_err(ctrl_err), .ovf(ovf)
    );

    ascii_stream_monitor #(.CNT_W(3), .WRD_W(8), .TIMEOUT(TIMEOUT), .TO_W(8)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .din(din), .din_valid(din_valid),
        .busy(s_busy), .msg_done(s_done), .msg_chars(s_chars), .msg_words(s_words),
        .msg_lines(s_lines), .msg_sum(s_sum), .msg_timeout(s_timeout),
        .ext_flag(s_ext), .ctrl_err(s_ctrl), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    logic [39:0] summ;
    logic [3:0]  summ_s;
    assign summ   = {msg_chars, msg_words, msg_lines, msg_sum, msg_timeout, ext_flag, ctrl_err, ovf};
    assign summ_s = {s_chars, s_ovf};

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: the bytes of the message in progress and the last summary.
    logic [7:0]  q[$];
    int          idle_cnt;
    logic        m_done, m_to, m_ext, m_ctrl, m_ovf, m_ovf_s;
    logic [11:0] m_chars;
    logic [2:0]  m_chars_s;
    logic [7:0]  m_words, m_lines, m_sum;

    function automatic bit is_sep_b(input logic [7:0] b);
        return b <= 8'h20;
    endfunction

    function automatic logic [39:0] exp_summ();
        return {m_chars, m_words, m_lines, m_sum, m_to, m_ext, m_ctrl, m_ovf};
    endfunction

    task automatic model_reset();
        q.delete();
        idle_cnt = 0;
        m_done = 1'b0; m_to = 1'b0; m_ext = 1'b0; m_ctrl = 1'b0; m_ovf = 1'b0; m_ovf_s = 1'b0;
        m_chars = 12'd0; m_chars_s = 3'd0; m_words = 8'd0; m_lines = 8'd0; m_sum = 8'd0;
    endtask

    // Summarise the whole message from its byte list.
    task automatic model_close(input logic to);
        int n, w, l;
        logic [7:0] s;
        logic e, c;
        n = q.size(); w = 0; l = 0; s = 8'd0; e = 1'b0; c = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!is_sep_b(q[i]) && (i == 0 || is_sep_b(q[i-1]))) w++;
            if (q[i] == 8'h0A) l++;
            s = s + q[i];
            if (q[i] >= 8'h80) e = 1'b1;
            if (q[i] < 8'h20 && q[i] != 8'h0A && q[i] != 8'h0D) c = 1'b1;
        end
        m_chars   = (n > 4095) ? 12'hFFF : 12'(n);
        m_chars_s = (n > 7) ? 3'h7 : 3'(n);
        m_words   = (w > 255) ? 8'hFF : 8'(w);
        m_lines   = (l > 255) ? 8'hFF : 8'(l);
        m_sum     = s;
        m_to      = to;
        m_ext     = e;
        m_ctrl    = c;
        m_ovf     = (n > 4095) || (w > 255) || (l > 255);
        m_ovf_s   = (n > 7) || (w > 255) || (l > 255);
        m_done    = 1'b1;
        q.delete();
        idle_cnt  = 0;
    endtask

    // Drive one cycle, advance the model on the edge, return 1 time unit later.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        din_valid = v; din = d; clear = c;
        @(posedge clk);
        m_done = 1'b0;
        if (c) begin
            q.delete();
            idle_cnt = 0;
        end else if (v) begin
            q.push_back(d);
            idle_cnt = 0;
            if (d == 8'h0A && q.size() >= 2 && q[q.size()-2] == 8'h2E) model_close(1'b0);
        end else if (q.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT) model_close(1'b1);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] b [5] = '{8'h41, 8'h2E, 8'h0A, 8'h42, 8'h43};
        reset = 1'b1; din_valid = 1'b0; clear = 1'b0; din = 8'h00;
        @(posedge clk); #1;
        model_reset();
        tests_run++;
        if ({busy, msg_done, summ, summ_s} !== 46'd0) begin
            tests_failed++; $display("FAIL reset_idle: got %h expected 0", {busy, msg_done, summ, summ_s});
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, b[i], 1'b0);
        tests_run++;
        if (busy !== 1'b1 || msg_chars !== 12'd3) begin
            tests_failed++; $display("FAIL pre_reset: got busy=%b chars=%0d expected busy=1 chars=3", busy, msg_chars);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if ({busy, msg_done, summ, summ_s} !== 46'd0) begin
            tests_failed++; $display("FAIL reset_mid: got %h expected 0", {busy, msg_done, summ, summ_s});
        end
        @(posedge clk); #1;
        tests_run++;
        if (msg_done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_hold: got done=%b busy=%b expected 0 0", msg_done, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_hi();
        logic [7:0] b [7] = '{8'h48, 8'h69, 8'h20, 8'h79, 8'h6F, 8'h2E, 8'h0A};
        for (int i = 0; i < 7; i++) begin
            step(1'b1, b[i], 1'b0);
            tests_run++;
            if (msg_done !== (i == 6) || busy !== (i != 6)) begin
                tests_failed++; $display("FAIL hi_timing[%0d]: got done=%b busy=%b expected done=%b busy=%b", i, msg_done, busy, i == 6, i != 6);
            end
        end
        tests_run++;
        if (summ !== {12'd7, 8'd2, 8'd1, 8'hF1, 4'b0000}) begin
            tests_failed++; $display("FAIL hi_summary: got %h expected %h", summ, {12'd7, 8'd2, 8'd1, 8'hF1, 4'b0000});
        end
        step(1'b0, 8'h00, 1'b0);
        tests_run++;
        if (msg_done !== 1'b0) begin
            tests_failed++; $display("FAIL hi_pulse_width: got done=%b expected 0", msg_done);
        end
    endtask

    task automatic test_timeout();
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h62, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(1'b0, 8'($urandom), 1'b0);
            tests_run++;
            if (msg_done !== (k == TIMEOUT) || busy !== (k < TIMEOUT)) begin
                tests_failed++; $display("FAIL timeout_timing[%0d]: got done=%b busy=%b expected done=%b busy=%b", k, msg_done, busy, k == TIMEOUT, k < TIMEOUT);
            end
        end
        tests_run++;
        if (summ !== {12'd2, 8'd1, 8'd0, 8'hC3, 4'b1000}) begin
            tests_failed++; $display("FAIL timeout_summary: got %h expected %h", summ, {12'd2, 8'd1, 8'd0, 8'hC3, 4'b1000});
        end
    endtask

    task automatic test_lines();
        logic [7:0] b [8] = '{8'h20, 8'h20, 8'h41, 8'h0A, 8'h0A, 8'h42, 8'h2E, 8'h0A};
        for (int i = 0; i < 8; i++) begin
            step(1'b1, b[i], 1'b0);
            tests_run++;
            if (msg_done !== (i == 7) || busy !== (i != 7)) begin
                tests_failed++; $display("FAIL lines_timing[%0d]: got done=%b busy=%b expected done=%b busy=%b", i, msg_done, busy, i == 7, i != 7);
            end
        end
        tests_run++;
        if (summ !== {12'd8, 8'd2, 8'd3, 8'h0F, 4'b0000}) begin
            tests_failed++; $display("FAIL lines_summary: got %h expected %h", summ, {12'd8, 8'd2, 8'd3, 8'h0F, 4'b0000});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [6] = '{8'hE1, 8'h09, 8'h2E, 8'h0A, 8'h2E, 8'h0A};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, b[i], 1'b0);
            tests_run++;
            if (msg_done !== (i == 3 || i == 5)) begin
                tests_failed++; $display("FAIL b2b_timing[%0d]: got done=%b expected %b", i, msg_done, i == 3 || i == 5);
            end
            if (i == 3) begin
                tests_run++;
                if (summ !== {12'd4, 8'd2, 8'd1, 8'h22, 4'b0110}) begin
                    tests_failed++; $display("FAIL b2b_first: got %h expected %h", summ, {12'd4, 8'd2, 8'd1, 8'h22, 4'b0110});
                end
            end
        end
        tests_run++;
        if (summ !== {12'd2, 8'd1, 8'd1, 8'h38, 4'b0000}) begin
            tests_failed++; $display("FAIL b2b_second: got %h expected %h", summ, {12'd2, 8'd1, 8'd1, 8'h38, 4'b0000});
        end
    endtask

    task automatic test_clear();
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h43, 1'b1);
        tests_run++;
        if (busy !== 1'b0 || msg_done !== 1'b0 || summ !== {12'd2, 8'd1, 8'd1, 8'h38, 4'b0000}) begin
            tests_failed++; $display("FAIL clear_drop: got busy=%b done=%b summ=%h expected 0 0 %h", busy, msg_done, summ, {12'd2, 8'd1, 8'd1, 8'h38, 4'b0000});
        end
        // A different message so the post-clear summary is distinguishable.
        step(1'b1, 8'h58, 1'b0);
        tests_run++;
        if (msg_done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL clear_restart: got done=%b busy=%b expected 0 1", msg_done, busy);
        end
        step(1'b1, 8'h2E, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        tests_run++;
        if (msg_done !== 1'b1 || summ !== {12'd3, 8'd1, 8'd1, 8'h90, 4'b0000} || summ_s !== {3'd3, 1'b0}) begin
            tests_failed++; $display("FAIL clear_summary: got done=%b summ=%h small=%h expected 1 %h %h", msg_done, summ, summ_s, {12'd3, 8'd1, 8'd1, 8'h90, 4'b0000}, {3'd3, 1'b0});
        end
    endtask

    task automatic test_sat();
        int pulses;
        for (int i = 0; i < 9; i++) step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h2E, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        tests_run++;
        if (msg_done !== 1'b1 || summ !== {12'd11, 8'd1, 8'd1, 8'h81, 4'b0000} || summ_s !== {3'd7, 1'b1}) begin
            tests_failed++; $display("FAIL sat_chars: got done=%b summ=%h small=%h expected 1 %h %h", msg_done, summ, summ_s, {12'd11, 8'd1, 8'd1, 8'h81, 4'b0000}, {3'd7, 1'b1});
        end
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 8'h0A, 1'b0);
            if (msg_done === 1'b1) pulses++;
        end
        step(1'b1, 8'h2E, 1'b0);
        step(1'b1, 8'h0A, 1'b0);
        tests_run++;
        if (pulses != 0 || msg_done !== 1'b1 || summ !== {12'd262, 8'd1, 8'd255, 8'h60, 4'b0001} || summ_s !== {3'd7, 1'b1}) begin
            tests_failed++; $display("FAIL sat_lines: got pulses=%0d done=%b summ=%h small=%h expected 0 1 %h %h", pulses, msg_done, summ, summ_s, {12'd262, 8'd1, 8'd255, 8'h60, 4'b0001}, {3'd7, 1'b1});
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
    } stim_t;

    task automatic test_random();
        stim_t sq[$];
        stim_t st;
        int r, len, gap;
        logic [7:0] b;
        for (int m = 0; m < 40; m++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2, 3: b = 8'($urandom_range(33, 126));
                    4:          b = 8'h20;
                    5:          b = 8'h0A;
                    6:          b = 8'($urandom_range(128, 255));
                    7:          b = 8'($urandom_range(0, 31));
                    default:    b = 8'h2E;
                endcase
                st.v = 1'b1; st.d = b; st.c = ($urandom_range(0, 24) == 0);
                sq.push_back(st);
                if ($urandom_range(0, 7) == 0) begin
                    gap = $urandom_range(1, 20);
                    for (int g = 0; g < gap; g++) begin
                        st.v = 1'b0; st.d = 8'($urandom); st.c = ($urandom_range(0, 40) == 0);
                        sq.push_back(st);
                    end
                end
            end
            if ($urandom_range(0, 2) != 0) begin
                st.v = 1'b1; st.c = 1'b0;
                st.d = 8'h2E; sq.push_back(st);
                st.d = 8'h0A; sq.push_back(st);
            end
        end
        for (int i = 0; i < sq.size(); i++) begin
            step(sq[i].v, sq[i].d, sq[i].c);
            tests_run++;
            if ({busy, msg_done, summ} !== {q.size() != 0, m_done, exp_summ()}) begin
                tests_failed++; $display("FAIL random[%0d]: got %h expected %h", i, {busy, msg_done, summ}, {q.size() != 0, m_done, exp_summ()});
            end
            tests_run++;
            if (summ_s !== {m_chars_s, m_ovf_s}) begin
                tests_failed++; $display("FAIL random_small[%0d]: got %h expected %h", i, summ_s, {m_chars_s, m_ovf_s});
            end
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; din = 8'h00; din_valid = 1'b0;
        model_reset();
        test_reset();
        test_hi();
        test_timeout();
        test_lines();
        test_back_to_back();
        test_clear();
        test_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
